// File: rtl/chord_sequencer.sv
// Beat-clocked chord progression generator: four 4-chord progressions, derived
// 4-note voicings spread over NUM_VOICES outputs, transposed and clamped to 0..127.
module chord_sequencer #(
    parameter int NUM_VOICES      = 16,
    parameter int BEATS_PER_CHORD = 8,
    parameter int BASE_NOTE       = 12
) (
    input  logic                    slow_clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [1:0]              prog_sel,
    input  logic [4:0]              transpose,
    output logic [7*NUM_VOICES-1:0] notes,
    output logic [1:0]              chord_idx,
    output logic [5:0]              beat_cnt,
    output logic                    chord_change,
    output logic                    prog_wrap
);

    localparam logic [5:0] LAST_BEAT = 6'(BEATS_PER_CHORD - 1);

    localparam logic [1:0] Q_MAJ7 = 2'd0;
    localparam logic [1:0] Q_DOM7 = 2'd1;
    localparam logic [1:0] Q_MIN7 = 2'd2;
    localparam logic [1:0] Q_MAJ6 = 2'd3;

    function automatic logic [3:0] chord_root(input logic [1:0] prog, input logic [1:0] idx);
        logic [3:0] root;
        case ({prog, idx})
            4'h0: root = 4'd0;  4'h1: root = 4'd5;  4'h2: root = 4'd9;  4'h3: root = 4'd7;
            4'h4: root = 4'd2;  4'h5: root = 4'd7;  4'h6: root = 4'd0;  4'h7: root = 4'd0;
            4'h8: root = 4'd9;  4'h9: root = 4'd2;  4'hA: root = 4'd7;  4'hB: root = 4'd0;
            4'hC: root = 4'd0;  4'hD: root = 4'd9;  4'hE: root = 4'd2;  default: root = 4'd7;
        endcase
        return root;
    endfunction

    function automatic logic [1:0] chord_qual(input logic [1:0] prog, input logic [1:0] idx);
        logic [1:0] qual;
        case ({prog, idx})
            4'h0: qual = Q_MAJ7;  4'h1: qual = Q_MAJ7;  4'h2: qual = Q_MIN7;  4'h3: qual = Q_MAJ6;
            4'h4: qual = Q_MIN7;  4'h5: qual = Q_DOM7;  4'h6: qual = Q_MAJ7;  4'h7: qual = Q_MAJ7;
            4'h8: qual = Q_MIN7;  4'h9: qual = Q_MIN7;  4'hA: qual = Q_DOM7;  4'hB: qual = Q_MAJ7;
            4'hC: qual = Q_MAJ7;  4'hD: qual = Q_MIN7;  4'hE: qual = Q_MIN7;  default: qual = Q_DOM7;
        endcase
        return qual;
    endfunction

    function automatic logic [3:0] chord_interval(input logic [1:0] qual, input logic [1:0] j);
        logic [3:0] ival;
        case (j)
            2'd0:    ival = 4'd0;
            2'd1:    ival = (qual == Q_MIN7) ? 4'd3 : 4'd4;
            2'd2:    ival = 4'd7;
            default: begin
                case (qual)
                    Q_MAJ7:  ival = 4'd11;
                    Q_MAJ6:  ival = 4'd9;
                    default: ival = 4'd10;
                endcase
            end
        endcase
        return ival;
    endfunction

    // k is the voice position within its 8-voice group: bass, then two octaves of the chord
    function automatic logic [6:0] voice_note(input logic [3:0] root, input logic [1:0] qual,
                                              input logic [4:0] trans, input logic [2:0] k);
        logic [2:0]        km1;
        logic [5:0]        offset;
        logic signed [8:0] sum;
        logic [6:0]        note;
        km1 = k - 3'd1;
        if (k == 3'd0) begin
            offset = 6'd0;
        end else begin
            offset = (km1[2] ? 6'd24 : 6'd12) + {2'b00, chord_interval(qual, km1[1:0])};
        end
        sum = 9'(BASE_NOTE) + {5'b00000, root} + {{4{trans[4]}}, trans} + {3'b000, offset};
        if (sum < 0) begin
            note = 7'd0;
        end else if (sum > 9'sd127) begin
            note = 7'd127;
        end else begin
            note = sum[6:0];
        end
        return note;
    endfunction

    logic [5:0]              r_beat_cnt;
    logic [1:0]              r_chord_idx;
    logic [1:0]              r_prog_q;
    logic [4:0]              r_trans_q;
    logic [7*NUM_VOICES-1:0] r_notes;
    logic                    r_chord_change;
    logic                    r_prog_wrap;

    logic                    w_boundary;
    logic                    w_load;
    logic [1:0]              w_idx;
    logic [1:0]              w_prog;
    logic [4:0]              w_trans;
    logic [3:0]              w_root;
    logic [1:0]              w_qual;
    logic [7*NUM_VOICES-1:0] w_notes;

    // Controls are only taken from the inputs when a new chord is loaded; otherwise
    // the latched copies keep the voicing stable.
    assign w_boundary = run && (r_beat_cnt == LAST_BEAT);
    assign w_load     = reset || w_boundary;
    assign w_idx      = reset ? 2'd0 : (w_boundary ? r_chord_idx + 2'd1 : r_chord_idx);
    assign w_prog     = w_load ? prog_sel  : r_prog_q;
    assign w_trans    = w_load ? transpose : r_trans_q;
    assign w_root     = chord_root(w_prog, w_idx);
    assign w_qual     = chord_qual(w_prog, w_idx);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign w_notes[7*v +: 7] = voice_note(w_root, w_qual, w_trans, 3'(v % 8));
    end

    always_ff @(posedge slow_clk) begin
        if (reset) begin
            r_beat_cnt     <= 6'd0;
            r_chord_idx    <= 2'd0;
            r_prog_q       <= prog_sel;
            r_trans_q      <= transpose;
            r_notes        <= w_notes;
            r_chord_change <= 1'b0;
            r_prog_wrap    <= 1'b0;
        end else if (run) begin
            r_chord_change <= w_boundary;
            r_prog_wrap    <= w_boundary && (r_chord_idx == 2'd3);
            if (w_boundary) begin
                r_beat_cnt  <= 6'd0;
                r_chord_idx <= w_idx;
                r_prog_q    <= prog_sel;
                r_trans_q   <= transpose;
                r_notes     <= w_notes;
            end else begin
                r_beat_cnt  <= r_beat_cnt + 6'd1;
            end
        end else begin
            r_chord_change <= 1'b0;
            r_prog_wrap    <= 1'b0;
        end
    end

    assign notes        = r_notes;
    assign chord_idx    = r_chord_idx;
    assign beat_cnt     = r_beat_cnt;
    assign chord_change = r_chord_change;
    assign prog_wrap    = r_prog_wrap;

endmodule
